// File: rtl/tcu_sequencer.sv
// Timing Control Unit and Instruction Register for the 6502 core.
// Holds the opcode and T state, stalls on RDY, and injects BRK for RESET/NMI/IRQ sequences.
module tcu_sequencer #(
  parameter int                IR_WIDTH   = 8,
  parameter int                TCU_WIDTH  = 3,
  parameter int                MAX_T      = 7,
  parameter logic [IR_WIDTH-1:0] BRK_OPCODE = 8'h00
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rdy,
  input  logic [IR_WIDTH-1:0]  i_data,
  input  logic                 i_end,
  input  logic                 i_nmi_n,
  input  logic                 i_irq_n,
  input  logic                 i_irq_mask,
  output logic [IR_WIDTH-1:0]  o_ir,
  output logic [TCU_WIDTH-1:0] o_tcu,
  output logic                 o_sync,
  output logic [1:0]           o_int_type,
  output logic                 o_nmi_pending,
  output logic                 o_error
);

  localparam logic [TCU_WIDTH-1:0] LP_T0    = TCU_WIDTH'(0);
  localparam logic [TCU_WIDTH-1:0] LP_T1    = TCU_WIDTH'(1);
  localparam logic [TCU_WIDTH-1:0] LP_MAX_T = TCU_WIDTH'(MAX_T);

  localparam logic [1:0] LP_INT_NONE  = 2'b00;
  localparam logic [1:0] LP_INT_IRQ   = 2'b01;
  localparam logic [1:0] LP_INT_NMI   = 2'b10;
  localparam logic [1:0] LP_INT_RESET = 2'b11;

  logic [IR_WIDTH-1:0]  r_ir;
  logic [TCU_WIDTH-1:0] r_tcu;
  logic                 r_sync;
  logic [1:0]           r_int_type;
  logic                 r_nmi_pending;
  logic                 r_nmi_q;
  logic                 r_error;

  logic [IR_WIDTH-1:0]  w_ir_n;
  logic [TCU_WIDTH-1:0] w_tcu_n;
  logic [1:0]           w_int_type_n;
  logic                 w_error_n;
  logic                 w_nmi_pending_n;
  logic                 w_nmi_edge;
  logic                 w_irq_req;
  logic                 w_inject_nmi;

  assign w_nmi_edge = r_nmi_q & ~i_nmi_n;
  assign w_irq_req  = ~i_irq_n & ~i_irq_mask;

  // Next-state decode for fetch/execute; everything holds while RDY is low.
  always_comb begin
    w_ir_n       = r_ir;
    w_tcu_n      = r_tcu;
    w_int_type_n = r_int_type;
    w_error_n    = r_error;
    w_inject_nmi = 1'b0;
    if (i_rdy) begin
      if (r_tcu == LP_T0) begin
        w_tcu_n = LP_T1;
        if (r_nmi_pending) begin
          w_ir_n       = BRK_OPCODE;
          w_int_type_n = LP_INT_NMI;
          w_inject_nmi = 1'b1;
        end else if (w_irq_req) begin
          w_ir_n       = BRK_OPCODE;
          w_int_type_n = LP_INT_IRQ;
        end else begin
          w_ir_n       = i_data;
          w_int_type_n = LP_INT_NONE;
        end
      end else begin
        if (i_end) begin
          w_tcu_n = LP_T0;
        end else if (r_tcu == LP_MAX_T) begin
          w_tcu_n   = LP_T0;
          w_error_n = 1'b1;
        end else begin
          w_tcu_n = r_tcu + LP_T1;
        end
      end
    end else begin
      w_inject_nmi = 1'b0;
    end
    // A fresh edge in the injection cycle must not be lost.
    if (w_nmi_edge) begin
      w_nmi_pending_n = 1'b1;
    end else if (w_inject_nmi) begin
      w_nmi_pending_n = 1'b0;
    end else begin
      w_nmi_pending_n = r_nmi_pending;
    end
  end

  // State register; reset starts the core directly at T1 of the reset sequence.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ir          <= BRK_OPCODE;
      r_tcu         <= LP_T1;
      r_sync        <= 1'b0;
      r_int_type    <= LP_INT_RESET;
      r_nmi_pending <= 1'b0;
      r_nmi_q       <= 1'b1;
      r_error       <= 1'b0;
    end else begin
      r_ir          <= w_ir_n;
      r_tcu         <= w_tcu_n;
      r_sync        <= (w_tcu_n == LP_T0);
      r_int_type    <= w_int_type_n;
      r_nmi_pending <= w_nmi_pending_n;
      r_nmi_q       <= i_nmi_n;
      r_error       <= w_error_n;
    end
  end

  assign o_ir          = r_ir;
  assign o_tcu         = r_tcu;
  assign o_sync        = r_sync;
  assign o_int_type    = r_int_type;
  assign o_nmi_pending = r_nmi_pending;
  assign o_error       = r_error;

endmodule

// File: tb/tb_tcu_sequencer.sv
// Directed self-checking bench for tcu_sequencer with hand-computed expectations.
module tb_tcu_sequencer;

  logic       clk_s = 1'b0;
  logic       reset_s;
  logic       rdy_s;
  logic [7:0] data_s;
  logic       end_s;
  logic       nmi_n_s;
  logic       irq_n_s;
  logic       irq_mask_s;
  logic [7:0] ir_s;
  logic [2:0] tcu_s;
  logic       sync_s;
  logic [1:0] int_type_s;
  logic       nmi_pending_s;
  logic       error_s;

  int checks_r = 0;
  int errors_r = 0;

  tcu_sequencer #(
    .IR_WIDTH  (8),
    .TCU_WIDTH (3),
    .MAX_T     (7),
    .BRK_OPCODE(8'h00)
  ) dut (
    .i_clk        (clk_s),
    .i_reset      (reset_s),
    .i_rdy        (rdy_s),
    .i_data       (data_s),
    .i_end        (end_s),
    .i_nmi_n      (nmi_n_s),
    .i_irq_n      (irq_n_s),
    .i_irq_mask   (irq_mask_s),
    .o_ir         (ir_s),
    .o_tcu        (tcu_s),
    .o_sync       (sync_s),
    .o_int_type   (int_type_s),
    .o_nmi_pending(nmi_pending_s),
    .o_error      (error_s)
  );

  always #5 clk_s = ~clk_s;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic step();
    @(posedge clk_s);
    #1;
  endtask

  initial begin
    reset_s = 1'b1; rdy_s = 1'b1; data_s = 8'h00; end_s = 1'b0;
    nmi_n_s = 1'b1; irq_n_s = 1'b1; irq_mask_s = 1'b1;
    step();
    check_eq("rst_ir", 32'(ir_s), 32'h00);
    check_eq("rst_tcu", 32'(tcu_s), 32'd1);
    check_eq("rst_int", 32'(int_type_s), 32'd3);
    check_eq("rst_pend", 32'(nmi_pending_s), 32'd0);
    check_eq("rst_err", 32'(error_s), 32'd0);
    check_eq("rst_sync", 32'(sync_s), 32'd0);
    reset_s = 1'b0;

    // Reset sequence T1..T6, end at T6.
    for (int t = 2; t <= 6; t++) begin
      step();
      check_eq("rstseq_tcu", 32'(tcu_s), 32'(t));
    end
    end_s = 1'b1;
    step();
    end_s = 1'b0;
    check_eq("rstseq_t0", 32'(tcu_s), 32'd0);
    check_eq("rstseq_sync", 32'(sync_s), 32'd1);
    check_eq("rstseq_ir", 32'(ir_s), 32'h00);
    check_eq("rstseq_int", 32'(int_type_s), 32'd3);

    // Minimum instruction A9 then fetch EA.
    data_s = 8'hA9;
    step();
    check_eq("a9_ir", 32'(ir_s), 32'hA9);
    check_eq("a9_tcu", 32'(tcu_s), 32'd1);
    check_eq("a9_int", 32'(int_type_s), 32'd0);
    check_eq("a9_sync", 32'(sync_s), 32'd0);
    end_s = 1'b1; data_s = 8'h55;
    step();
    check_eq("a9_end_tcu", 32'(tcu_s), 32'd0);
    check_eq("a9_end_ir", 32'(ir_s), 32'hA9);
    end_s = 1'b0; data_s = 8'hEA;
    step();
    check_eq("ea_ir", 32'(ir_s), 32'hEA);
    check_eq("ea_tcu", 32'(tcu_s), 32'd1);

    // RDY stall at T2.
    end_s = 1'b1;
    step();
    end_s = 1'b0; data_s = 8'hA9;
    step();
    step();
    check_eq("stall_pre_tcu", 32'(tcu_s), 32'd2);
    rdy_s = 1'b0; data_s = 8'h33; end_s = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("stall_tcu", 32'(tcu_s), 32'd2);
      check_eq("stall_ir", 32'(ir_s), 32'hA9);
    end
    rdy_s = 1'b1; end_s = 1'b0;
    step();
    check_eq("unstall_tcu", 32'(tcu_s), 32'd3);

    // NMI edge mid-instruction with IRQ also asserted.
    irq_n_s = 1'b0; irq_mask_s = 1'b0; nmi_n_s = 1'b0;
    step();
    check_eq("nmi_tcu", 32'(tcu_s), 32'd4);
    check_eq("nmi_pend_set", 32'(nmi_pending_s), 32'd1);
    end_s = 1'b1;
    step();
    check_eq("nmi_pend_hold", 32'(nmi_pending_s), 32'd1);
    end_s = 1'b0; data_s = 8'hEA;
    step();
    check_eq("nmi_ir", 32'(ir_s), 32'h00);
    check_eq("nmi_int", 32'(int_type_s), 32'd2);
    check_eq("nmi_pend_clr", 32'(nmi_pending_s), 32'd0);
    end_s = 1'b1;
    step();
    end_s = 1'b0;
    step();
    check_eq("irq_ir", 32'(ir_s), 32'h00);
    check_eq("irq_int", 32'(int_type_s), 32'd1);
    check_eq("no_2nd_nmi", 32'(nmi_pending_s), 32'd0);

    // Masked IRQ, then software BRK.
    end_s = 1'b1;
    step();
    end_s = 1'b0; irq_mask_s = 1'b1; data_s = 8'hEA;
    step();
    check_eq("mask_ir", 32'(ir_s), 32'hEA);
    check_eq("mask_int", 32'(int_type_s), 32'd0);
    end_s = 1'b1;
    step();
    end_s = 1'b0; data_s = 8'h00;
    step();
    check_eq("swbrk_ir", 32'(ir_s), 32'h00);
    check_eq("swbrk_int", 32'(int_type_s), 32'd0);

    // Overrun past MAX_T.
    for (int t = 2; t <= 7; t++) begin
      step();
      check_eq("ovr_tcu", 32'(tcu_s), 32'(t));
    end
    check_eq("ovr_err_pre", 32'(error_s), 32'd0);
    data_s = 8'hA9;
    step();
    check_eq("ovr_wrap", 32'(tcu_s), 32'd0);
    check_eq("ovr_err", 32'(error_s), 32'd1);
    step();
    check_eq("ovr_next_ir", 32'(ir_s), 32'hA9);
    step();
    step();
    step();
    check_eq("mid_tcu", 32'(tcu_s), 32'd4);
    check_eq("err_sticky", 32'(error_s), 32'd1);

    // Reset mid-instruction.
    reset_s = 1'b1;
    step();
    reset_s = 1'b0;
    check_eq("rst2_tcu", 32'(tcu_s), 32'd1);
    check_eq("rst2_int", 32'(int_type_s), 32'd3);
    check_eq("rst2_err", 32'(error_s), 32'd0);
    check_eq("rst2_ir", 32'(ir_s), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule

// File: doc/tcu_sequencer.md
Name: tcu_sequencer

Overview:
Parametrised Timing Control Unit plus Instruction Register for the 6502 core. It replaces the fixed IR = 8'h00 and TCU = 3'b000 placeholders at the CPU top level. It holds the current opcode and timing state, and stalls on RDY. It latches RESET/NMI/IRQ requests and injects a BRK opcode at the next fetch boundary to run interrupt sequences. The Decoder consumes o_ir, o_tcu and o_int_type.

Parameters:
IR_WIDTH, 8, opcode width.
TCU_WIDTH, 3, timing-state counter width.
MAX_T, 7, highest legal T state. Must satisfy 1 <= MAX_T <= 2**TCU_WIDTH-1.
BRK_OPCODE, 8'h00, opcode injected for interrupt/reset sequences (IR_WIDTH bits).

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_reset  in  1  synchronous reset, active-high
i_rdy  in  1  1 = advance; 0 = freeze o_ir/o_tcu
i_data  in  IR_WIDTH  opcode from input data latch (DL)
i_end  in  1  from Decoder: current cycle is the last cycle of the instruction
i_nmi_n  in  1  NMI request, falling-edge triggered
i_irq_n  in  1  IRQ request, level, active-low
i_irq_mask  in  1  P.I flag; 1 = IRQ masked
o_ir  out  IR_WIDTH  instruction register
o_tcu  out  TCU_WIDTH  current T state
o_sync  out  1  high while o_tcu == 0 (opcode fetch cycle)
o_int_type  out  2  00 none/BRK, 01 IRQ, 10 NMI, 11 RESET
o_nmi_pending  out  1  latched NMI not yet serviced
o_error  out  1  sticky: instruction overran MAX_T without i_end

Behaviour:
- Reset (i_reset=1 at edge; takes priority over everything, including mid-instruction):
  - o_ir=BRK_OPCODE, o_tcu=1, o_int_type=11, o_nmi_pending=0, o_error=0.
  - NMI edge register preset to 1.
  - Result: the core starts the reset sequence directly at T1, with no fetch.
- All state except the NMI edge logic is held while i_rdy=0.
- NMI edge detect:
  - nmi_q <= i_nmi_n every cycle, regardless of i_rdy.
  - On (nmi_q==1 && i_nmi_n==0), set nmi_pending.
  - Clear nmi_pending when an NMI is injected.
  - If a new edge and an injection occur in the same cycle, set wins and nmi_pending stays 1.
- irq_req = !i_irq_n && !i_irq_mask, evaluated combinationally at fetch. IRQ is not latched.
- Fetch (o_tcu==0 && i_rdy), next state:
  - If nmi_pending: o_ir<=BRK_OPCODE, o_int_type<=10.
  - Else if irq_req: o_ir<=BRK_OPCODE, o_int_type<=01.
  - Else: o_ir<=i_data, o_int_type<=00.
  - In all cases o_tcu<=1.
  - A software BRK fetched from memory yields o_int_type=00.
- Execute (o_tcu!=0 && i_rdy), next state:
  - If i_end: o_tcu<=0.
  - Else if o_tcu==MAX_T: o_tcu<=0 and o_error<=1 (sticky until reset).
  - Else: o_tcu<=o_tcu+1.
  - o_ir and o_int_type are held throughout execute.
- o_sync = (o_tcu==0), decoded from the register with no extra latency.
- Latency:
  - Opcode presented on i_data during a T0 cycle with i_rdy=1 appears on o_ir the next cycle, with o_tcu=1.
  - A minimum instruction (i_end asserted at T1) takes 2 cycles.
- i_end while o_tcu==0 is ignored.
- o_tcu never exceeds MAX_T and never wraps past it.

Test Plan:
- Reset then release, i_end pulsed when o_tcu==6 -> o_ir=8'h00, o_int_type=11, o_tcu sequence 1..6, then 0, with o_sync=1 at 0.
- Fetch with i_data=8'hA9, i_end at T1 -> o_ir=8'hA9, o_int_type=00, o_tcu 0,1,0; the next fetch with i_data=8'hEA gives o_ir=8'hEA.
- i_rdy=0 for 3 cycles at o_tcu=2 -> o_tcu/o_ir frozen at 2/8'hA9; on i_rdy=1 o_tcu advances to 3.
- i_nmi_n falls mid-instruction while i_irq_n=0 and i_irq_mask=0 -> o_nmi_pending=1. At the next fetch o_ir=8'h00 and o_int_type=10 (NMI beats IRQ); o_nmi_pending clears. With i_nmi_n held low, no second NMI occurs.
- i_irq_n=0: with i_irq_mask=1, fetch of 8'hEA gives o_ir=8'hEA and o_int_type=00; with mask=0, o_ir=8'h00 and o_int_type=01.
- MAX_T=7, i_end never asserted -> o_tcu 1..7 then 0, o_error=1 and remaining 1 across later instructions; i_reset mid-instruction at o_tcu=4 -> next cycle o_tcu=1, o_int_type=11, o_error=0.
